// File: rtl/parallel_to_serial.sv
// Purpose: parallel word to LSB-first serial stream with per-word width and a word-end marker.
// Latency: bit 0 appears one clock after the word is accepted; bit k follows k clocks later.
// Backpressure: a one-word holding buffer; ready drops while it is full, and the serial side has no stall.
//
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous, active-high reset
//   width      bits per word, sampled with the word (0 or > max_width means max_width)
//   load       producer valid for data/width
//   data       parallel word, bit 0 shifted out first
//   ready      holding buffer empty; the word is taken on an edge with load && ready
//   out        serial bit
//   out_valid  out carries a bit of a word this cycle
//   last       out carries the final bit of the current word
module parallel_to_serial #(
    parameter int max_width = 16,
    localparam int bits = (max_width <= 2)  ? 0 :
                          (max_width <= 4)  ? 1 :
                          (max_width <= 8)  ? 2 :
                          (max_width <= 16) ? 3 :
                          (max_width <= 32) ? 4 :
                          (max_width <= 64) ? 5 : -1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [bits:0]        width,
    input  logic                 load,
    input  logic [max_width-1:0] data,
    output logic                 ready,
    output logic                 out,
    output logic                 out_valid,
    output logic                 last
);

    // One extra bit over the width port so that max_width itself fits
    // in the latched width (the width port encodes max_width as 0).
    localparam int wreg_w = bits + 2;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t               state;
    logic [max_width-1:0] shreg;
    logic [bits:0]        cnt;
    logic [wreg_w-1:0]    wreg;

    logic                 hold_full;
    logic [max_width-1:0] hold_dat;
    logic [wreg_w-1:0]    hold_w;

    logic                 free;
    logic                 accept;
    logic                 src_vld;
    logic [max_width-1:0] src_dat;
    logic [wreg_w-1:0]    src_w;
    logic [wreg_w-1:0]    cnt_inc;

    // Map the width port onto the number of bits actually sent.
    function automatic logic [wreg_w-1:0] eff_of(input logic [bits:0] w);
        if (w == '0 || int'(w) > max_width)
            return wreg_w'(max_width);
        else
            return wreg_w'(w);
    endfunction

    // ready is a straight register output so the producer never sees a
    // combinational path from its own load back to ready.
    assign ready  = !hold_full;
    assign accept = load && !hold_full;

    // The shifter can take a new word when empty or when showing its last bit.
    assign free   = (state == IDLE) || last;

    assign cnt_inc = {1'b0, cnt} + wreg_w'(1);

    // Next word source: the held word has priority; otherwise the input word
    // can bypass the holding buffer straight into the shifter.
    always_comb begin
        src_vld = 1'b0;
        src_dat = '0;
        src_w   = '0;
        if (hold_full) begin
            src_vld = 1'b1;
            src_dat = hold_dat;
            src_w   = hold_w;
        end else if (load) begin
            src_vld = 1'b1;
            src_dat = data;
            src_w   = eff_of(width);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            shreg     <= '0;
            cnt       <= '0;
            wreg      <= '0;
            hold_full <= 1'b0;
            hold_dat  <= '0;
            hold_w    <= '0;
            out       <= 1'b0;
            out_valid <= 1'b0;
            last      <= 1'b0;
        end else begin
            if (free && src_vld) begin
                // Start a new word: bit 0 goes out now, the rest stays in shreg.
                shreg     <= src_dat >> 1;
                out       <= src_dat[0];
                out_valid <= 1'b1;
                cnt       <= (bits + 1)'(1);
                wreg      <= src_w;
                last      <= (src_w == wreg_w'(1));
                state     <= SHIFT;
                if (hold_full)
                    hold_full <= 1'b0;
            end else if (state == SHIFT && !last) begin
                out   <= shreg[0];
                shreg <= shreg >> 1;
                cnt   <= cnt_inc[bits:0];
                last  <= (cnt_inc == wreg);
            end else if (free) begin
                out       <= 1'b0;
                out_valid <= 1'b0;
                last      <= 1'b0;
                state     <= IDLE;
            end

            // A word accepted while the shifter is busy waits in the holding
            // buffer. Acceptance implies the buffer is empty, so a word can
            // never be held and drained on the same edge.
            if (accept && !free) begin
                hold_full <= 1'b1;
                hold_dat  <= data;
                hold_w    <= eff_of(width);
            end
        end
    end

endmodule

// File: tb/tb_parallel_to_serial.sv
// Purpose: self-checking bench for parallel_to_serial against a queue-based bit-stream model.
// Latency: outputs are compared on every falling edge, half a cycle after the updating rising edge.
// Backpressure: the model tracks the single held word to predict ready.
module tb_parallel_to_serial;

    localparam int MW = 16;

    logic        clock;
    logic        reset;
    logic [3:0]  width;
    logic        load;
    logic [15:0] data;
    logic        ready;
    logic        out;
    logic        out_valid;
    logic        last;

    int checks = 0;
    int errors = 0;

    parallel_to_serial #(.max_width(MW)) dut (
        .clock    (clock),
        .reset    (reset),
        .width    (width),
        .load     (load),
        .data     (data),
        .ready    (ready),
        .out      (out),
        .out_valid(out_valid),
        .last     (last)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: the bits still to be shown, in order, each tagged with
    // whether it ends its word; the front entry is the bit currently on out.
    typedef struct {
        logic b;
        logic l;
    } sbit_t;

    sbit_t       m_q[$];
    logic        m_held;
    logic [15:0] m_hd;
    int          m_hw;

    function automatic int eff_w(input logic [3:0] w);
        if (w == 0 || int'(w) > MW) return MW;
        return int'(w);
    endfunction

    task automatic push_word(input logic [15:0] d, input int n);
        sbit_t s;
        for (int i = 0; i < n; i++) begin
            s.b = d[i];
            s.l = (i == n - 1);
            m_q.push_back(s);
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_outputs();
        check("ready", 32'(ready), 32'(!m_held));
        check("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
        if (m_q.size() > 0) begin
            check("out", 32'(out), 32'(m_q[0].b));
            check("last", 32'(last), 32'(m_q[0].l));
        end else begin
            check("out_idle", 32'(out), 32'd0);
            check("last_idle", 32'(last), 32'd0);
        end
    endtask

    // One clock: advance the model with the inputs present at the rising
    // edge, then compare on the falling edge.
    task automatic tick();
        bit acc;
        bit fr;
        @(posedge clock);
        fr  = (m_q.size() <= 1);
        acc = load && !m_held;
        if (m_q.size() > 0) void'(m_q.pop_front());
        if (fr && m_held) begin
            push_word(m_hd, m_hw);
            m_held = 1'b0;
        end else if (fr && acc) begin
            push_word(data, eff_w(width));
            acc = 1'b0;
        end
        if (acc) begin
            m_held = 1'b1;
            m_hd   = data;
            m_hw   = eff_w(width);
        end
        @(negedge clock);
        compare_outputs();
    endtask

    task automatic model_reset();
        m_q.delete();
        m_held = 1'b0;
        m_hd   = '0;
        m_hw   = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check("rst_out", 32'(out), 32'd0);
        check("rst_vld", 32'(out_valid), 32'd0);
        check("rst_last", 32'(last), 32'd0);
        check("rst_ready", 32'(ready), 32'd1);
        @(negedge clock);
        reset = 1'b0;
    endtask

    int n_valid;

    initial begin
        reset = 1'b1;
        load  = 1'b0;
        data  = '0;
        width = '0;
        model_reset();
        @(negedge clock);
        do_reset();

        // Full-width word from idle: 16 bits of A5C3, last only on the 16th.
        load = 1'b1; data = 16'hA5C3; width = 4'd0;
        tick();
        load = 1'b0; data = 16'h0000; width = 4'd7;
        n_valid = 1;
        for (int i = 0; i < 18; i++) begin
            tick();
            if (out_valid) n_valid++;
        end
        check("a5c3_len", 32'(n_valid), 32'd16);

        // Width 3: first word bypasses, second is held, then streams behind.
        load = 1'b1; data = 16'h0005; width = 4'd3;
        tick();
        data = 16'h0002;
        tick();
        load = 1'b0;
        for (int i = 0; i < 8; i++) tick();

        // Width 1 with load held: one bit per word, ready never drops.
        width = 4'd1;
        for (int i = 0; i < 12; i++) begin
            load = 1'b1;
            data = 16'(i & 1) ^ 16'h1;
            tick();
        end
        load = 1'b0;
        tick();
        tick();

        // Load exactly when the last bit is on the wire.
        load = 1'b1; data = 16'h00F0; width = 4'd4;
        tick();
        load = 1'b0;
        while (!last && m_q.size() > 0) tick();
        load = 1'b1; data = 16'h0009; width = 4'd4;
        tick();
        load = 1'b0;
        for (int i = 0; i < 6; i++) tick();

        // Reset after bit 5 of a 16-bit word; the next word starts clean.
        load = 1'b1; data = 16'hBEEF; width = 4'd0;
        tick();
        load = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        do_reset();
        load = 1'b1; data = 16'h1234; width = 4'd0;
        tick();
        load = 1'b0;
        for (int i = 0; i < 17; i++) tick();

        // Width 15 then 16, with the width port changing mid-word.
        load = 1'b1; data = 16'hFFFF; width = 4'd15;
        tick();
        data = 16'h8001; width = 4'd0;
        tick();
        load = 1'b0;
        for (int i = 0; i < 34; i++) begin
            width = 4'($urandom_range(0, 15));
            tick();
        end

        // Randomized traffic: bursty load, random data and width every cycle.
        for (int i = 0; i < 3000; i++) begin
            load  = ($urandom_range(0, 3) != 0);
            data  = 16'($urandom);
            width = 4'($urandom_range(0, 15));
            tick();
            if ($urandom_range(0, 499) == 0) do_reset();
        end
        load = 1'b0;
        for (int i = 0; i < 40; i++) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
